// File: rtl/ej32_con_tx.sv
// eJ32 console transmit: snoops output-buffer writes, queues them and sends 8N1 on tx.
// Define EJ32_CON_PARITY_EN to add an even-parity bit (8E1 frames).
module ej32_con_tx #(
    parameter int OBUF   = 'h1400,
    parameter int OBSZ   = 'h0400,
    parameter int ASZ    = 17,
    parameter int FDEPTH = 16,
    parameter int DIV    = 868
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [ASZ-1:0] wr_addr,
    input  logic [7:0]     wr_data,
    output logic           full,
    output logic           ovf,
    output logic           tx,
    output logic           tx_busy,
    output logic [15:0]    tx_cnt
);
    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DIV);
    localparam logic [ASZ:0] LO = (ASZ+1)'(OBUF);
    localparam logic [ASZ:0] HI = (ASZ+1)'(OBUF + OBSZ);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef EJ32_CON_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    mem [FDEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count;
    logic [BW-1:0] baud;
    logic [2:0]    bitn;
    logic [7:0]    sh;
`ifdef EJ32_CON_PARITY_EN
    logic          par;
`endif
    logic          in_win;
    logic          bit_done;
    logic          pop;
    logic          push;
    logic [7:0]    head;

    assign in_win   = ({1'b0, wr_addr} >= LO) && ({1'b0, wr_addr} < HI);
    assign bit_done = (baud == BW'(DIV - 1));
    assign full     = (count == CW'(FDEPTH));
    assign tx_busy  = (state != IDLE) || (count != '0);
    assign head     = mem[rp];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign pop  = (count != '0) &&
                  ((state == IDLE) || ((state == STOP) && bit_done));
    assign push = wr_en && in_win && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            baud   <= '0;
            bitn   <= '0;
            sh     <= '0;
`ifdef EJ32_CON_PARITY_EN
            par    <= 1'b0;
`endif
            ovf    <= 1'b0;
            tx     <= 1'b1;
            tx_cnt <= '0;
        end else begin
            if (push)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (wr_en && in_win && full && !pop)
                ovf <= 1'b1;

            if (state == IDLE || bit_done)
                baud <= '0;
            else
                baud <= baud + BW'(1);

            if (pop) begin
                sh    <= head;
`ifdef EJ32_CON_PARITY_EN
                par   <= ^head;
`endif
                state <= START;
                tx    <= 1'b0;
            end

            unique case (state)
                IDLE: ;
                START: begin
                    if (bit_done) begin
                        state <= DATA;
                        tx    <= sh[0];
                        bitn  <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bitn <= bitn + 3'd1;
                        sh   <= sh >> 1;
                        if (bitn == 3'd7) begin
`ifdef EJ32_CON_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= sh[1];
                        end
                    end
                end
`ifdef EJ32_CON_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        tx_cnt <= tx_cnt + 16'd1;
                        if (!pop)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ej32_con_tx.sv
// Scoreboard bench for ej32_con_tx: UART receiver model checks every sent byte.
module tb_ej32_con_tx;
    localparam int DIV    = 4;
    localparam int FDEPTH = 4;
    localparam int ASZ    = 17;
`ifdef EJ32_CON_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_en = 1'b0;
    logic [ASZ-1:0] wr_addr = '0;
    logic [7:0]     wr_data = '0;
    logic           full;
    logic           ovf;
    logic           tx;
    logic           tx_busy;
    logic [15:0]    tx_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    bit rx_en = 1'b1;
    logic [7:0] exp_q[$];
    int starts[$];

    ej32_con_tx #(
        .OBUF('h1400), .OBSZ('h0400), .ASZ(ASZ), .FDEPTH(FDEPTH), .DIV(DIV)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .full(full), .ovf(ovf), .tx(tx),
        .tx_busy(tx_busy), .tx_cnt(tx_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ASZ-1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && (exp_q.size() != 0 || tx_busy); i++)
            step(1);
        chk("drain_timeout", 32'(i < 3000), 1);
        step(4);
    endtask

    // UART receiver: samples one cycle into each bit and checks the scoreboard
    always begin
        logic [7:0] b;
        logic p;
        logic s;
        logic st;
        logic [7:0] e;
        @(negedge clk);
        if (tx === 1'b0 && !rst) begin
            starts.push_back(cyc);
            @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                b[i] = tx;
            end
            p = 1'b0;
`ifdef EJ32_CON_PARITY_EN
            repeat (DIV) @(negedge clk);
            p = tx;
`endif
            repeat (DIV) @(negedge clk);
            s = tx;
            if (rx_en) begin
                chk("rx_start", 32'(st), 0);
                chk("rx_stop", 32'(s), 1);
`ifdef EJ32_CON_PARITY_EN
                chk("rx_parity", 32'(p), 32'(^b));
`endif
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", 32'(b), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_byte", 32'(b), 32'(e));
                end
            end
        end
    end

    initial begin
        // 1: reset state
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_cnt", 32'(tx_cnt), 0);

        // 2: single byte, latency and frame length
        exp_q.push_back(8'h41);
        wr(17'h1400, 8'h41);
        chk("lat_n1_tx", 32'(tx), 1);
        step(1);
        chk("lat_n2_tx", 32'(tx), 0);
        chk("lat_busy", 32'(tx_busy), 1);
        step(FRAME - 1);
        chk("stop_tx", 32'(tx), 1);
        chk("cnt_before", 32'(tx_cnt), 0);
        step(1);
        chk("cnt_after", 32'(tx_cnt), 1);
        chk("idle_busy", 32'(tx_busy), 0);
        drain();

        // 3: window boundaries
        wr(17'h13FF, 8'h55);
        wr(17'h1800, 8'h55);
        step(10);
        chk("oob_tx", 32'(tx), 1);
        chk("oob_cnt", 32'(tx_cnt), 1);
        chk("oob_busy", 32'(tx_busy), 0);
        exp_q.push_back(8'h5A);
        wr(17'h17FF, 8'h5A);
        drain();
        chk("top_cnt", 32'(tx_cnt), 2);

        // 4: overflow and back-to-back frames
        do_rst();
        starts.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5)
                exp_q.push_back(8'(i));
            wr(17'h1400 + 17'(i), 8'(i));
        end
        chk("ovf_full", 32'(full), 1);
        chk("ovf_set", 32'(ovf), 1);
        drain();
        chk("b2b_cnt", 32'(tx_cnt), 5);
        chk("b2b_frames", 32'(starts.size()), 5);
        for (int i = 1; i < starts.size(); i++)
            chk("b2b_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
        chk("ovf_sticky", 32'(ovf), 1);

        // 5: write while full coinciding with pop is accepted
        do_rst();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            wr(17'h1500, 8'h10 + 8'(i));
        end
        chk("pf_full", 32'(full), 1);
        step(FRAME - 4);
        exp_q.push_back(8'h99);
        wr(17'h1500, 8'h99);
        chk("pf_full2", 32'(full), 1);
        chk("pf_ovf", 32'(ovf), 0);
        drain();
        chk("pf_cnt", 32'(tx_cnt), 6);
        chk("pf_ovf_end", 32'(ovf), 0);

        // 6: reset mid data bit 3 with bytes queued
        do_rst();
        rx_en = 1'b0;
        wr(17'h1400, 8'h07);
        wr(17'h1400, 8'h08);
        wr(17'h1400, 8'h09);
        step(16);
        chk("mid_tx_low", 32'(tx), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("abort_tx", 32'(tx), 1);
        chk("abort_busy", 32'(tx_busy), 0);
        chk("abort_cnt", 32'(tx_cnt), 0);
        step(60);
        chk("abort_idle_tx", 32'(tx), 1);
        chk("abort_idle_cnt", 32'(tx_cnt), 0);
        rx_en = 1'b1;
        exp_q.push_back(8'h07);
        wr(17'h1400, 8'h07);
        drain();
        chk("post_cnt", 32'(tx_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
